// File: rtl/mem_responder_if.sv
// mem_responder_if -- request/response bundle between the icache/dcache
// requesters and the line-memory responder.
//   i_req/i_req_addr          icache line read request (level)
//   i_res/i_res_addr/_data    icache response (one-cycle pulse)
//   d_req/d_req_addr          dcache line read request (level)
//   d_res/d_res_addr/_data    dcache response (one-cycle pulse)
//   d_write/_addr/_data       dcache line write-back (one-cycle pulse)
// master: requester side, slave: responder side.
interface mem_responder_if #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned LINE_SIZE = 128
);
  logic                 i_req;
  logic [WORD_SIZE-1:0] i_req_addr;
  logic                 i_res;
  logic [WORD_SIZE-1:0] i_res_addr;
  logic [LINE_SIZE-1:0] i_res_data;
  logic                 d_req;
  logic [WORD_SIZE-1:0] d_req_addr;
  logic                 d_res;
  logic [WORD_SIZE-1:0] d_res_addr;
  logic [LINE_SIZE-1:0] d_res_data;
  logic                 d_write;
  logic [WORD_SIZE-1:0] d_write_addr;
  logic [LINE_SIZE-1:0] d_write_data;

  modport master (
    output i_req, i_req_addr, d_req, d_req_addr,
           d_write, d_write_addr, d_write_data,
    input  i_res, i_res_addr, i_res_data, d_res, d_res_addr, d_res_data
  );

  modport slave (
    input  i_req, i_req_addr, d_req, d_req_addr,
           d_write, d_write_addr, d_write_data,
    output i_res, i_res_addr, i_res_data, d_res, d_res_addr, d_res_data
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder -- fixed-latency line memory serving an icache and a dcache.
// One read is in flight at a time (dcache has priority on acceptance); a
// request accepted at edge T is answered with a one-cycle res pulse
// registered at edge T+LATENCY. dcache write-backs arriving while a read is
// in flight are parked in one pending register and applied on the next IDLE
// edge, ahead of any read captured on that edge.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (array contents are kept)
//   bus  mem_responder_if slave modport (request/response/write-back signals)
module mem_responder #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned LINE_SIZE = 128,
  parameter int unsigned LATENCY   = 5,
  parameter int unsigned DEPTH     = 256
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int unsigned OFF = $clog2(LINE_SIZE / 8);
  localparam int unsigned IW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(LATENCY);
  localparam logic [WORD_SIZE-1:0] ALIGN_MASK =
    ~WORD_SIZE'((64'd1 << OFF) - 64'd1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 port_d;
  logic [WORD_SIZE-1:0] cap_addr;

  logic                 pend_valid;
  logic [IW-1:0]        pend_idx;
  logic [LINE_SIZE-1:0] pend_data;

  logic                 i_res_q;
  logic [WORD_SIZE-1:0] i_res_addr_q;
  logic [LINE_SIZE-1:0] i_res_data_q;
  logic                 d_res_q;
  logic [WORD_SIZE-1:0] d_res_addr_q;
  logic [LINE_SIZE-1:0] d_res_data_q;

  // Zero at time zero; deliberately untouched by rst.
  logic [LINE_SIZE-1:0] mem [DEPTH] = '{default: '0};

  // Whole-word shift then truncate: upper bits alias modulo DEPTH lines.
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  assign wr_idx = IW'(bus.d_write_addr >> OFF);
  assign rd_idx = IW'(cap_addr >> OFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      port_d       <= 1'b0;
      cap_addr     <= '0;
      pend_valid   <= 1'b0;
      pend_idx     <= '0;
      pend_data    <= '0;
      i_res_q      <= 1'b0;
      i_res_addr_q <= '0;
      i_res_data_q <= '0;
      d_res_q      <= 1'b0;
      d_res_addr_q <= '0;
      d_res_data_q <= '0;
    end else begin
      i_res_q <= 1'b0;
      d_res_q <= 1'b0;
      case (state)
        IDLE: begin
          // Any pending write lands in the array at this edge.
          pend_valid <= 1'b0;
          if (bus.d_req) begin
            port_d   <= 1'b1;
            cap_addr <= bus.d_req_addr & ALIGN_MASK;
            cnt      <= CW'(LATENCY - 2);
            state    <= WAIT;
          end else if (bus.i_req) begin
            port_d   <= 1'b0;
            cap_addr <= bus.i_req_addr & ALIGN_MASK;
            cnt      <= CW'(LATENCY - 2);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (port_d) begin
            d_res_q      <= 1'b1;
            d_res_addr_q <= cap_addr;
            d_res_data_q <= mem[rd_idx];
          end else begin
            i_res_q      <= 1'b1;
            i_res_addr_q <= cap_addr;
            i_res_data_q <= mem[rd_idx];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Later write-backs overwrite the parked one (same line by contract).
      if (state != IDLE && bus.d_write) begin
        pend_valid <= 1'b1;
        pend_idx   <= wr_idx;
        pend_data  <= bus.d_write_data;
      end
    end
  end

  // Array is never written outside IDLE, so the RESP read sees every write
  // applied up to that point. A direct write follows the pending one so it
  // wins when both target the same line.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (pend_valid) begin
        mem[pend_idx] <= pend_data;
      end
      if (bus.d_write) begin
        mem[wr_idx] <= bus.d_write_data;
      end
    end
  end

  assign bus.i_res      = i_res_q;
  assign bus.i_res_addr = i_res_addr_q;
  assign bus.i_res_data = i_res_data_q;
  assign bus.d_res      = d_res_q;
  assign bus.d_res_addr = d_res_addr_q;
  assign bus.d_res_data = d_res_data_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder -- directed bench for mem_responder (LATENCY=5, DEPTH=256,
// 16-byte lines): a vector table of writes/reads plus hand-written sequences
// for arbitration, deferred write-back, aliasing and mid-transaction reset.
module tb_mem_responder;

  localparam int unsigned LAT = 5;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  mem_responder_if #(.WORD_SIZE(32), .LINE_SIZE(128)) bus ();

  mem_responder #(
    .WORD_SIZE(32),
    .LINE_SIZE(128),
    .LATENCY  (LAT),
    .DEPTH    (256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  typedef struct {
    int           op;       // 0 write, 1 icache read, 2 dcache read
    logic [31:0]  addr;
    logic [127:0] data;
    logic [31:0]  exp_addr;
    logic [127:0] exp_data;
    string        name;
  } vec_t;

  localparam logic [127:0] D1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [127:0] D2 = 128'hdead_beef_0000_1111_2222_3333_cafe_f00d;
  localparam logic [127:0] D3 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] D4 = 128'h1357_9bdf_2468_ace0_1357_9bdf_2468_ace0;
  localparam logic [127:0] D5 = 128'hbad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0;
  localparam logic [127:0] A5 = {16{8'hA5}};

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [127:0] data);
    bus.d_write      = 1'b1;
    bus.d_write_addr = addr;
    bus.d_write_data = data;
    @(posedge clk); #1;
    bus.d_write = 1'b0;
  endtask

  // Raises the request, counts edges until res; lat = edges after acceptance.
  task automatic do_read(input bit is_d, input logic [31:0] addr, output int lat,
                         output logic [31:0] ra, output logic [127:0] rd, output bit wrong);
    wrong = 1'b0;
    lat   = -1;
    ra    = '0;
    rd    = '0;
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_req_addr = addr;
    end else begin
      bus.i_req = 1'b1; bus.i_req_addr = addr;
    end
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (is_d ? bus.i_res : bus.d_res) wrong = 1'b1;
      if (is_d ? bus.d_res : bus.i_res) begin
        lat = n - 1;
        ra  = is_d ? bus.d_res_addr : bus.i_res_addr;
        rd  = is_d ? bus.d_res_data : bus.i_res_data;
        break;
      end
    end
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    int           lat;
    logic [31:0]  ra;
    logic [127:0] rd;
    bit           wrong;
    int           d_at;
    int           i_at;
    logic [127:0] d_data;
    logic [31:0]  i_addr;

    vecs[0] = '{1, 32'h0000_1004, '0, 32'h0000_1000, '0, "first_read"};
    vecs[1] = '{0, 32'h0000_1000, D1, '0, '0, "wr_1000"};
    vecs[2] = '{2, 32'h0000_100C, '0, 32'h0000_1000, D1, "d_rd_1000"};
    vecs[3] = '{1, 32'h0000_2000, '0, 32'h0000_2000, D1, "alias_rd"};
    vecs[4] = '{0, 32'h0000_2FF0, D2, '0, '0, "wr_top"};
    vecs[5] = '{2, 32'h0000_0FF8, '0, 32'h0000_0FF0, D2, "top_line"};
    vecs[6] = '{1, 32'h0000_0010, '0, 32'h0000_0010, '0, "line1_zero"};
    vecs[7] = '{0, 32'hFFFF_0010, D3, '0, '0, "wr_hi_alias"};
    vecs[8] = '{2, 32'h0000_001F, '0, 32'h0000_0010, D3, "line1_wr"};

    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.i_req = 1'b0; bus.i_req_addr = '0;
    bus.d_req = 1'b0; bus.d_req_addr = '0;
    bus.d_write = 1'b0; bus.d_write_addr = '0; bus.d_write_data = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_i_res", 128'(bus.i_res), 128'(0));
    check("rst_d_res", 128'(bus.d_res), 128'(0));
    check("rst_i_addr", 128'(bus.i_res_addr), 128'(0));
    check("rst_d_addr", 128'(bus.d_res_addr), 128'(0));
    check("rst_i_data", bus.i_res_data, '0);
    check("rst_d_data", bus.d_res_data, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].op == 0) begin
        do_write(vecs[v].addr, vecs[v].data);
      end else begin
        do_read(vecs[v].op == 2, vecs[v].addr, lat, ra, rd, wrong);
        check({vecs[v].name, "_lat"}, 128'(lat), 128'(LAT));
        check({vecs[v].name, "_addr"}, 128'(ra), 128'(vecs[v].exp_addr));
        check({vecs[v].name, "_data"}, rd, vecs[v].exp_data);
        check({vecs[v].name, "_otherport"}, 128'(wrong), 128'(0));
        @(posedge clk); #1;
        check({vecs[v].name, "_pulse1"}, 128'({bus.i_res, bus.d_res}), 128'(0));
      end
    end

    // Simultaneous requests: dcache first, icache accepted on the next IDLE edge.
    d_at = -1; i_at = -1; i_addr = '0;
    bus.d_req = 1'b1; bus.d_req_addr = 32'h0000_0800;
    bus.i_req = 1'b1; bus.i_req_addr = 32'h0000_0904;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (bus.d_res) begin d_at = n - 1; bus.d_req = 1'b0; end
      if (bus.i_res) begin i_at = n - 1; i_addr = bus.i_res_addr; bus.i_req = 1'b0; break; end
    end
    bus.d_req = 1'b0; bus.i_req = 1'b0;
    check("prio_d_lat", 128'(d_at), 128'(5));
    check("prio_i_lat", 128'(i_at), 128'(11));
    check("prio_i_addr", 128'(i_addr), 128'(32'h0000_0900));
    @(posedge clk); #1;

    // Write-back during an icache WAIT, with a dcache read of the same line
    // queued so it is captured on the edge the pending write is applied.
    i_at = -1; d_at = -1; d_data = '0;
    bus.i_req = 1'b1; bus.i_req_addr = 32'h0000_0300;
    @(posedge clk); #1;                       // edge 1: icache accepted
    bus.d_req = 1'b1; bus.d_req_addr = 32'h0000_0040;
    @(posedge clk); #1;                       // edge 2
    bus.d_write = 1'b1; bus.d_write_addr = 32'h0000_0048; bus.d_write_data = A5;
    @(posedge clk); #1;                       // edge 3: write parked
    bus.d_write = 1'b0;
    for (int n = 4; n <= 30; n++) begin
      @(posedge clk); #1;
      if (bus.i_res) begin i_at = n - 1; bus.i_req = 1'b0; end
      if (bus.d_res) begin d_at = n - 1; d_data = bus.d_res_data; bus.d_req = 1'b0; break; end
    end
    bus.d_req = 1'b0; bus.i_req = 1'b0;
    check("wb_i_lat", 128'(i_at), 128'(5));
    check("wb_d_lat", 128'(d_at), 128'(11));
    check("wb_d_data", d_data, A5);
    @(posedge clk); #1;

    // Reset in WAIT: aborts the read, drops the parked write, keeps the array.
    do_write(32'h0000_0500, D4);
    i_at = -1; d_data = '0;
    bus.i_req = 1'b1; bus.i_req_addr = 32'h0000_0504;
    @(posedge clk); #1;                       // edge 1: accepted
    @(posedge clk); #1;                       // edge 2
    bus.d_write = 1'b1; bus.d_write_addr = 32'h0000_0500; bus.d_write_data = D5;
    @(posedge clk); #1;                       // edge 3: D5 parked
    bus.d_write = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_i_addr", 128'(bus.i_res_addr), 128'(0));
    check("rst_mid_d_data", bus.d_res_data, '0);
    @(posedge clk); #1;                       // edge 4
    rst = 1'b0;
    for (int n = 5; n <= 30; n++) begin
      @(posedge clk); #1;
      if (bus.i_res) begin i_at = n; d_data = bus.i_res_data; bus.i_req = 1'b0; break; end
    end
    bus.i_req = 1'b0;
    check("rst_reaccept_edge", 128'(i_at), 128'(10));
    check("rst_persist_data", d_data, D4);
    @(posedge clk); #1;
    check("rst_pulse1", 128'({bus.i_res, bus.d_res}), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
